// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoding constants and loader types.
// Used by the instruction packer, the loader top and the control decoder.
package rv_isa_pkg;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JALR   = 3'd5,
        CLS_JAL    = 3'd6,
        CLS_ILL    = 3'd7
    } instr_class_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_e;

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// Combinational RV32I field packer with immediate range/alignment check.
// legal is low for the illegal class or an immediate that does not fit.
module instr_pack
    import rv_isa_pkg::*;
(
    input  logic [2:0]  cls,
    input  logic [2:0]  f3,
    input  logic        f7b5,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [20:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    logic fits12;
    logic fits13;
    logic is_shift;

    assign fits12   = (imm[20:11] == {10{imm[11]}});
    assign fits13   = (imm[20:12] == {9{imm[12]}});
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // Select the instruction format for the class and check the immediate.
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (instr_class_e'(cls))
            CLS_R: begin
                word  = {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, OP_R};
                legal = 1'b1;
            end
            CLS_I: begin
                if (is_shift) begin
                    word = {1'b0, f7b5, 5'b0, imm[4:0], rs1, f3, rd, OP_I};
                end else begin
                    word = {imm[11:0], rs1, f3, rd, OP_I};
                end
                legal = fits12;
            end
            CLS_LOAD: begin
                word  = {imm[11:0], rs1, f3, rd, OP_LOAD};
                legal = fits12;
            end
            CLS_JALR: begin
                word  = {imm[11:0], rs1, f3, rd, OP_JALR};
                legal = fits12;
            end
            CLS_STORE: begin
                word  = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
                legal = fits12;
            end
            CLS_BRANCH: begin
                word  = {imm[12], imm[10:5], rs2, rs1, f3,
                         imm[4:1], imm[11], OP_BRANCH};
                legal = fits13 && !imm[0];
            end
            CLS_JAL: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                legal = !imm[0];
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction-memory loader: encodes field-level requests and writes them
// to consecutive words while holding the core in reset until loading ends.
module instr_encoder_loader
    import rv_isa_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              load_end,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_class,
    input  logic [2:0]        req_funct3,
    input  logic              req_f7b5,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [20:0]       req_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err,
    output logic              cpu_rst_n
);

    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

    ld_state_e         state_q, state_d;
    logic              end_pend_q, end_pend_d;
    logic [ADDR_W:0]   cnt_q, cnt_d, cnt_b;
    logic              err_q, err_d, err_b;
    logic              full_q, full_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              crst_q, crst_d;

    logic [31:0] pk_word;
    logic        pk_legal;
    logic        accept;
    logic        wr;
    logic        rej;

    instr_pack u_pack (
        .cls   (req_class),
        .f3    (req_funct3),
        .f7b5  (req_f7b5),
        .rd    (req_rd),
        .rs1   (req_rs1),
        .rs2   (req_rs2),
        .imm   (req_imm),
        .word  (pk_word),
        .legal (pk_legal)
    );

    // A final word accepted with load_end blocks further requests.
    assign req_ready = (state_q == ST_LOAD) && !full_q && !end_pend_q;
    assign accept    = req_valid && req_ready;
    assign wr        = accept && pk_legal;
    assign rej       = accept && !pk_legal;

    // Next-state: session control, write pointer and registered outputs.
    always_comb begin
        state_d    = state_q;
        end_pend_d = end_pend_q;
        cnt_b      = load_start ? '0 : cnt_q;
        err_b      = load_start ? 1'b0 : err_q;
        cnt_d      = cnt_b;
        err_d      = err_b | rej;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if (wr) begin
            we_d    = 1'b1;
            addr_d  = cnt_b[ADDR_W-1:0];
            wdata_d = pk_word;
            cnt_d   = cnt_b + CNT_ONE;
        end
        full_d = (cnt_d == CNT_FULL);
        if (load_start) begin
            state_d    = ST_LOAD;
            end_pend_d = 1'b0;
        end else if (state_q == ST_LOAD) begin
            if (end_pend_q) begin
                state_d    = ST_DONE;
                end_pend_d = 1'b0;
            end else if (load_end) begin
                if (wr) begin
                    end_pend_d = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
        end
        crst_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            end_pend_q <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            full_q     <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            crst_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            end_pend_q <= end_pend_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            full_q     <= full_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            crst_q     <= crst_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = cnt_q;
    assign full       = full_q;
    assign err        = err_q;
    assign cpu_rst_n  = crst_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader with a field-arithmetic
// reference encoder and a small session model (DEPTH=4).
module tb_instr_encoder_loader;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load_start = 1'b0;
    logic          load_end = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_class = '0;
    logic [2:0]    req_funct3 = '0;
    logic          req_f7b5 = 1'b0;
    logic [4:0]    req_rd = '0;
    logic [4:0]    req_rs1 = '0;
    logic [4:0]    req_rs2 = '0;
    logic [20:0]   req_imm = '0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   word_count;
    logic          full;
    logic          err;
    logic          cpu_rst_n;

    instr_encoder_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_end   (load_end),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_class  (req_class),
        .req_funct3 (req_funct3),
        .req_f7b5   (req_f7b5),
        .req_rd     (req_rd),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .word_count (word_count),
        .full       (full),
        .err        (err),
        .cpu_rst_n  (cpu_rst_n)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bit m_load = 0;
    bit m_done = 0;
    bit m_err  = 0;
    int m_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference encoder: bit positions from the RV32I formats, int arithmetic.
    task automatic ref_enc(input int cls, input int f3, input int f7, input int rd,
                           input int rs1, input int rs2, input int imm,
                           output bit legal, output logic [31:0] w);
        int u;
        int base;
        u     = imm;
        base  = (rs1 << 15) | (f3 << 12);
        legal = 0;
        w     = '0;
        case (cls)
            0: begin
                w = (f7 << 30) | (rs2 << 20) | base | (rd << 7) | 'h33;
                legal = 1;
            end
            1, 2, 5: begin
                legal = (imm >= -2048) && (imm <= 2047);
                if (cls == 1 && (f3 == 1 || f3 == 5))
                    w = (f7 << 30) | ((u & 31) << 20) | base | (rd << 7) | 'h13;
                else
                    w = ((u & 'hfff) << 20) | base | (rd << 7) |
                        (cls == 1 ? 'h13 : cls == 2 ? 'h03 : 'h67);
            end
            3: begin
                legal = (imm >= -2048) && (imm <= 2047);
                w = (((u >> 5) & 'h7f) << 25) | (rs2 << 20) | base |
                    ((u & 31) << 7) | 'h23;
            end
            4: begin
                legal = (imm >= -4096) && (imm <= 4095) && ((u & 1) == 0);
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) |
                    (rs2 << 20) | base | (((u >> 1) & 15) << 8) |
                    (((u >> 11) & 1) << 7) | 'h63;
            end
            6: begin
                legal = ((u & 1) == 0);
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3ff) << 21) |
                    (((u >> 11) & 1) << 20) | (((u >> 12) & 'hff) << 12) |
                    (rd << 7) | 'h6f;
            end
            default: legal = 0;
        endcase
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_count"}, 32'(word_count), 32'(m_cnt));
        chk({tag, "_full"}, 32'(full), 32'(m_cnt == DEPTH));
        chk({tag, "_err"}, 32'(err), 32'(m_err));
        chk({tag, "_cpurst"}, 32'(cpu_rst_n), 32'(m_done));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 0);
        chk({tag, "_we"}, 32'(imem_we), 0);
        chk({tag, "_addr"}, 32'(imem_addr), 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_count"}, 32'(word_count), 0);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_cpurst"}, 32'(cpu_rst_n), 0);
    endtask

    // Called just after a rising edge; returns whether the request was taken.
    task automatic send(input int cls, input int f3, input int f7, input int rd,
                        input int rs1, input int rs2, input int imm,
                        input bit with_end, input bit use_lit,
                        input logic [31:0] lit, output bit acc);
        bit          lg;
        bit          mr;
        logic [31:0] w;
        ref_enc(cls, f3, f7, rd, rs1, rs2, imm, lg, w);
        req_class  = 3'(cls);
        req_funct3 = 3'(f3);
        req_f7b5   = 1'(f7);
        req_rd     = 5'(rd);
        req_rs1    = 5'(rs1);
        req_rs2    = 5'(rs2);
        req_imm    = 21'(imm);
        req_valid  = 1'b1;
        acc = 0;
        for (int n = 0; n < 4 && !acc; n++) begin
            @(negedge clk);
            mr = m_load && (m_cnt < DEPTH);
            chk("req_ready", 32'(req_ready), 32'(mr));
            if (mr) begin
                acc = 1;
                if (lg) begin
                    sb.push_back('{32'(m_cnt), use_lit ? lit : w});
                    m_cnt++;
                end else begin
                    m_err = 1;
                end
                if (with_end) load_end = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        load_end  = 1'b0;
        if (with_end && acc) begin
            if (lg) begin
                chk("end_pending_cpurst", 32'(cpu_rst_n), 0);
                @(posedge clk);
                #1;
            end
            m_load = 0;
            m_done = 1;
            chk("end_release_cpurst", 32'(cpu_rst_n), 1);
        end
    endtask

    task automatic do_start();
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        m_load = 1;
        m_done = 0;
        m_cnt  = 0;
        m_err  = 0;
        chk_status("start");
    endtask

    task automatic do_end();
        load_end = 1'b1;
        @(posedge clk);
        #1;
        load_end = 1'b0;
        if (m_load) begin
            m_load = 0;
            m_done = 1;
        end
        chk_status("end");
    endtask

    function automatic int rnd_imm();
        int bl[10] = '{2047, -2048, 2048, -2049, 4094, -4096, 4095, 4096,
                       1048574, -1048576};
        case ($urandom_range(0, 5))
            0: return int'($urandom_range(0, 63)) - 32;
            1: return bl[$urandom_range(0, 9)];
            2: return int'($urandom_range(0, 2097151)) - 1048576;
            3: return (int'($urandom_range(0, 4095)) - 2048) * 2;
            4: return (int'($urandom_range(0, 1048575)) - 524288) * 2;
            default: return int'($urandom_range(0, 4095)) - 2048;
        endcase
    endfunction

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        exp_t e;
        if (imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %h data %h, none expected",
                         imem_addr, imem_wdata);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 32'(imem_addr), e.addr);
                chk("wr_data", imem_wdata, e.data);
            end
        end
    end

    initial begin
        bit acc;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("idle");

        // Load and release
        do_start();
        send(0, 0, 0, 3, 1, 2, 0, 0, 1, 32'h002081B3, acc);
        send(1, 0, 0, 1, 0, 0, 5, 0, 1, 32'h00500093, acc);
        chk_status("two_words");
        do_end();

        // BRANCH / JAL / STORE encodings, final word accepted with load_end
        do_start();
        send(4, 0, 0, 0, 1, 2, 8, 0, 1, 32'h00208463, acc);
        send(6, 0, 0, 1, 0, 0, 16, 0, 1, 32'h010000EF, acc);
        send(3, 2, 0, 0, 1, 2, 12, 1, 1, 32'h0020A623, acc);
        chk_status("sw_end");

        // Rejections leave the pointer and set err
        do_start();
        send(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, acc);
        send(7, 0, 0, 1, 1, 1, 0, 0, 0, 0, acc);
        send(4, 0, 0, 0, 1, 2, 7, 0, 0, 0, acc);
        send(1, 0, 0, 1, 0, 0, 2048, 0, 0, 0, acc);
        chk_status("rejects");
        send(1, 0, 0, 2, 0, 0, 7, 0, 1, 32'h00700113, acc);
        chk_status("after_reject");

        // Restart mid-session clears pointer, count and err
        do_start();
        send(1, 5, 1, 4, 3, 0, 3, 0, 1, 32'h4031D213, acc);

        // Fill to DEPTH, fifth request is held
        for (int i = 0; i < 3; i++) begin
            send(1, 0, 0, i + 1, i, 0, i * 3 - 2, 0, 0, 0, acc);
        end
        chk_status("full");
        chk("full_ready", 32'(req_ready), 0);
        send(1, 0, 0, 9, 9, 0, 9, 0, 0, 0, acc);
        chk("fifth_held", 32'(acc), 0);
        do_end();

        // Randomised sessions
        for (int i = 0; i < 80; i++) begin
            if (!m_load) do_start();
            if (m_cnt == DEPTH || ($urandom_range(0, 9) == 0 && m_cnt > 0)) begin
                do_end();
            end else begin
                send($urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 1), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 31),
                     rnd_imm(), ($urandom_range(0, 7) == 0), 0, 0, acc);
                chk_status("rand");
            end
        end

        // Reset mid-stream drops the write accepted on the reset edge
        if (!m_load) do_start();
        send(0, 0, 1, 5, 6, 7, 0, 0, 0, 0, acc);
        req_class = 3'd1;
        req_imm   = 21'd1;
        req_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        m_load = 0;
        m_done = 0;
        m_cnt  = 0;
        m_err  = 0;
        chk_reset("midrst");
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 0);
        chk_status("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
